disp_bcd_driver: RTL and testbench
==================================

# disp_bcd_driver

Two-digit seven-segment display driver between the Nios system's display PIO and the board pins DISP1_D (tens) and DISP0_D (units). It captures an 8-bit binary value on a load strobe and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine. It then registers the segment codes onto the display outputs. Values above 99 show an overflow pattern, and a busy/done pair tells software when the display has updated.

## Interface
- ACTIVE_LOW, 1: 1 = segments lit by driving 0 (common-anode board); 0 = all output bits inverted relative to the codes below.
- BLANK_LEADING_ZERO, 1: 1 = tens digit blanked when it is 0; 0 = tens digit shows "0".

- clock_50MHz  input  1  system clock; every register uses its rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  8  unsigned binary value to display.
- load  input  1  one-cycle request to capture value; sampled on the clock edge.
- busy  output  1  high while a capture/conversion is in progress.
- done  output  1  one-cycle pulse when the display outputs have just been updated.
- DISP1_D  output  8  tens digit; bit0..bit6 = segments a..g, bit7 = decimal point.
- DISP0_D  output  8  units digit; same bit map as DISP1_D.

## Operation
- Segment codes at ACTIVE_LOW=1 (dp always off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - dash "-"=BF, blank=FF
  - ACTIVE_LOW=0 drives the bitwise complement of each code.
- FSM states: IDLE, CONV, UPDATE, OVF.
- IDLE: when load=1, capture value into the shift register, clear the BCD registers and the iteration counter, and assert busy.
  - If value>99, next state is OVF.
  - Otherwise, next state is CONV.
- CONV: runs exactly 8 iterations, counter 0..7. Each iteration is one cycle:
  - add 3 to each BCD nibble that is ≥5;
  - then shift {tens, units, bin} left by 1.
  - After the iteration with counter=7, go to UPDATE.
- UPDATE: on a single edge:
  - load the segment codes into DISP1_D/DISP0_D;
  - apply BLANK_LEADING_ZERO to the tens digit;
  - pulse done;
  - drop busy;
  - return to IDLE.
- OVF: on a single edge, drive both outputs to dash, pulse done, drop busy, and return to IDLE. No conversion runs.
- load while busy=1 is ignored and not queued. Software must wait for busy=0.
- The display outputs hold their last value between updates and never change mid-conversion.
- BCD nibbles are 4 bits and the shift register is 8 bits. Inputs ≤99 never produce a tens nibble above 9.

## Timing
- Reset values while reset is high and after release:
  - DISP1_D = DISP0_D = blank (FF at ACTIVE_LOW=1);
  - busy=0, done=0;
  - state IDLE, counter 0.
- Reset asserted mid-conversion aborts immediately to the reset values. A load on the first edge after release is accepted.
- Normal path, with load sampled at edge k:
  - busy=1 after edge k;
  - conversion iterations occur on edges k+1..k+8;
  - outputs update and done=1 after edge k+9;
  - busy=0 and done=0 after edge k+10.
  - Total latency is 9 cycles from the load edge to the display change.
- Overflow path, with load at edge k: outputs show dash and done=1 after edge k+1. busy is high for exactly one cycle.
- The earliest accepted follow-up load is at edge k+10 on the normal path, or k+2 on the overflow path. busy is already 0 in the cycle before that edge.
- load and reset together: reset wins.

## Test plan
- Reset behaviour: assert reset mid-cycle, asynchronously → DISP1_D=FF, DISP0_D=FF, busy=0, done=0 immediately, with no clock edge needed.
- Normal conversion: value=42, load at edge k → busy high for edges k..k+9, DISP1_D=99, DISP0_D=A4 after edge k+9, done high for exactly one cycle.
- Leading-zero blanking: value=7 → DISP1_D=FF, DISP0_D=F8. Rebuild with BLANK_LEADING_ZERO=0 → DISP1_D=C0. Also value=0 → DISP1_D=FF, DISP0_D=C0.
- Maximum and overflow: value=99 → 90/90. value=100 → BF/BF one edge after load, done pulse. value=255 → BF/BF.
- Load while busy: load 42 at edge k and 99 at edge k+3 → display 99/A4, with one done pulse only. Then load 99 at edge k+10 → 90/90 after edge k+19.
- Reset mid-operation: load 58, assert reset at k+4 → outputs FF, busy 0, and no done pulse. After release, load 13 → 9/13 segment codes F9/B0 after 9 cycles.
- ACTIVE_LOW=0 build: value=42 → DISP1_D=66, DISP0_D=5B.

Source files
------------

// File: rtl/disp_bcd_driver.sv
// Two-digit seven-segment driver: captures an 8-bit value, converts it to BCD
// with a sequential shift-add-3 engine, then registers the segment codes.
module disp_bcd_driver #(
   parameter bit ACTIVE_LOW         = 1'b1,
   parameter bit BLANK_LEADING_ZERO = 1'b1
) (
   input  logic       clock_50MHz,
   input  logic       reset,
   input  logic [7:0] value,
   input  logic       load,
   output logic       busy,
   output logic       done,
   output logic [7:0] DISP1_D,
   output logic [7:0] DISP0_D
);

   localparam int unsigned DW = 8;
   localparam int unsigned NW = 4;
   localparam int unsigned CW = 3;

   // Codes are stored active-low; POL flips them for common-cathode builds.
   localparam logic [DW-1:0] POL       = ACTIVE_LOW ? 8'h00 : 8'hFF;
   localparam logic [DW-1:0] SEG_BLANK = 8'hFF ^ POL;
   localparam logic [DW-1:0] SEG_DASH  = 8'hBF ^ POL;

   typedef enum logic [1:0] {IDLE, CONV, UPDATE, OVF} state_t;

   state_t          state;
   logic [DW-1:0]   bin;
   logic [NW-1:0]   tens;
   logic [NW-1:0]   units;
   logic [CW-1:0]   cnt;
   logic [NW-1:0]   tens_adj_c;
   logic [NW-1:0]   units_adj_c;

   function automatic logic [DW-1:0] seg_code(input logic [NW-1:0] d);
      logic [DW-1:0] c;
      case (d)
         4'd0:    c = 8'hC0;
         4'd1:    c = 8'hF9;
         4'd2:    c = 8'hA4;
         4'd3:    c = 8'hB0;
         4'd4:    c = 8'h99;
         4'd5:    c = 8'h92;
         4'd6:    c = 8'h82;
         4'd7:    c = 8'hF8;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h90;
         default: c = 8'hFF;
      endcase
      return c ^ POL;
   endfunction

   assign tens_adj_c  = (tens  >= 4'd5) ? tens  + 4'd3 : tens;
   assign units_adj_c = (units >= 4'd5) ? units + 4'd3 : units;

   // Control FSM, double-dabble datapath and registered display outputs.
   always_ff @(posedge clock_50MHz or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bin     <= '0;
         tens    <= '0;
         units   <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         DISP1_D <= SEG_BLANK;
         DISP0_D <= SEG_BLANK;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  bin   <= value;
                  tens  <= '0;
                  units <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= (value > 8'd99) ? OVF : CONV;
               end
            end
            CONV: begin
               {tens, units, bin} <= 16'({tens_adj_c, units_adj_c, bin} << 1);
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) state <= UPDATE;
            end
            UPDATE: begin
               DISP1_D <= (BLANK_LEADING_ZERO && tens == 4'd0) ? SEG_BLANK : seg_code(tens);
               DISP0_D <= seg_code(units);
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            OVF: begin
               DISP1_D <= SEG_DASH;
               DISP0_D <= SEG_DASH;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_disp_bcd_driver.sv
// Bench for disp_bcd_driver: three builds (default, no blanking, active-high)
// driven in parallel and checked against a decimal-arithmetic display model.
module tb_disp_bcd_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] value;
   logic       load;

   logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
   logic [7:0] d1_a, d0_a, d1_b, d0_b, d1_c, d0_c;

   int nvec = 0;
   int nerr = 0;
   int shown = -1;   // value currently on the display, -1 = blank after reset

   localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                       8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   always #5 clk = ~clk;

   disp_bcd_driver #(.ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b1)) dut_a (
      .clock_50MHz(clk), .reset(reset), .value(value), .load(load),
      .busy(busy_a), .done(done_a), .DISP1_D(d1_a), .DISP0_D(d0_a));

   disp_bcd_driver #(.ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b0)) dut_b (
      .clock_50MHz(clk), .reset(reset), .value(value), .load(load),
      .busy(busy_b), .done(done_b), .DISP1_D(d1_b), .DISP0_D(d0_b));

   disp_bcd_driver #(.ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b1)) dut_c (
      .clock_50MHz(clk), .reset(reset), .value(value), .load(load),
      .busy(busy_c), .done(done_c), .DISP1_D(d1_c), .DISP0_D(d0_c));

   function automatic logic [7:0] exp_seg(input int v, input bit tens,
                                          input bit al, input bit blz);
      logic [7:0] c;
      int d;
      if (v < 0)       c = 8'hFF;
      else if (v > 99) c = 8'hBF;
      else begin
         d = tens ? v / 10 : v % 10;
         if (tens && d == 0 && blz) c = 8'hFF;
         else                       c = SEG[d];
      end
      return al ? c : ~c;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic b, input logic d);
      chk({tag, "_busy_a"}, 8'(busy_a), 8'(b));
      chk({tag, "_done_a"}, 8'(done_a), 8'(d));
      chk({tag, "_busy_c"}, 8'(busy_c), 8'(b));
      chk({tag, "_done_b"}, 8'(done_b), 8'(d));
      chk({tag, "_d1_a"}, d1_a, exp_seg(shown, 1'b1, 1'b1, 1'b1));
      chk({tag, "_d0_a"}, d0_a, exp_seg(shown, 1'b0, 1'b1, 1'b1));
      chk({tag, "_d1_b"}, d1_b, exp_seg(shown, 1'b1, 1'b1, 1'b0));
      chk({tag, "_d0_b"}, d0_b, exp_seg(shown, 1'b0, 1'b1, 1'b0));
      chk({tag, "_d1_c"}, d1_c, exp_seg(shown, 1'b1, 1'b0, 1'b1));
      chk({tag, "_d0_c"}, d0_c, exp_seg(shown, 1'b0, 1'b0, 1'b1));
   endtask

   // Load v on the next edge (k) and follow it cycle by cycle to the update;
   // intr adds an ignored load of 99 on edge k+3. Returns after edge k+9 (or k+1).
   task automatic run(input int v, input bit intr);
      value = 8'(v);
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check_all("load", 1'b1, 1'b0);
      if (v > 99) begin
         @(negedge clk);
         shown = v;
         check_all("ovf", 1'b0, 1'b1);
      end else begin
         for (int i = 1; i <= 8; i++) begin
            if (intr && i == 3) begin
               value = 8'd99;
               load  = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
            check_all("conv", 1'b1, 1'b0);
         end
         @(negedge clk);
         shown = v;
         check_all("update", 1'b0, 1'b1);
      end
   endtask

   initial begin
      int v;
      reset = 1'b1;
      load  = 1'b0;
      value = 8'd0;
      repeat (3) @(negedge clk);
      check_all("rst_hold", 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check_all("rst_rel", 1'b0, 1'b0);

      run(42, 1'b0);
      @(negedge clk);
      check_all("idle42", 1'b0, 1'b0);
      run(7, 1'b0);
      run(0, 1'b0);
      run(99, 1'b0);
      run(100, 1'b0);
      run(255, 1'b0);
      @(negedge clk);
      check_all("idle255", 1'b0, 1'b0);

      // Load while busy is dropped; back-to-back load at k+10 is accepted.
      run(42, 1'b1);
      run(99, 1'b0);
      @(negedge clk);
      check_all("idle99", 1'b0, 1'b0);

      // Asynchronous reset in the middle of a conversion.
      value = 8'd58;
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check_all("load58", 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 shown = -1;
      check_all("async_rst", 1'b0, 1'b0);
      repeat (2) begin
         @(negedge clk);
         check_all("rst_abort", 1'b0, 1'b0);
      end
      reset = 1'b0;
      run(13, 1'b0);

      for (int n = 0; n < 24; n++) begin
         v = int'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) v = int'($urandom_range(95, 105));
         run(v, $urandom_range(0, 4) == 0);
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            check_all("rnd_idle", 1'b0, 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
